// File: rtl/uart_tx.sv
// uart_tx: FIFO-fed UART transmitter. Pops one word per frame from a
// fall-through FIFO and serialises it as start bit, data bits LSB first,
// optional parity bit and STOP_BITS stop bits, each CLKS_PER_BIT cycles long.
// Optional feature macro: UART_TX_PARITY_EN (adds one parity bit after the data
// bits; PARITY_ODD selects odd parity).
//
// FIFO handshake: i_fifo_data is valid whenever i_fifo_empty is low. A word
// transfers in any cycle where o_fifo_rd_en is high; o_fifo_rd_en is only ever
// raised while i_fifo_empty is low, so the strobe doubles as "valid & ready".
// The word is captured on the same clock edge that retires the pop.
module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_tx_en,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    output logic                  o_fifo_rd_en,
    output logic                  o_tx,
    output logic                  o_busy
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = 3;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state;
    logic [TW-1:0]         timer;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] shreg;

    logic bit_end;
    logic last_data;
    logic last_stop;
    logic can_pop;

    assign bit_end   = (timer == TW'(CLKS_PER_BIT - 1));
    assign last_data = (idx == IW'(DATA_WIDTH - 1));
    assign last_stop = (idx == IW'(STOP_BITS - 1));
    assign can_pop   = i_tx_en && !i_fifo_empty;

    // Pop strobe: from IDLE, or in the final stop cycle to chain frames back to back.
    assign o_fifo_rd_en = can_pop &&
                          ((state == IDLE) ||
                           ((state == STOP) && bit_end && last_stop));

    // Frame sequencer with registered line and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            timer  <= '0;
            idx    <= '0;
            shreg  <= '0;
            o_tx   <= 1'b1;
            o_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timer  <= '0;
                    idx    <= '0;
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                    if (o_fifo_rd_en) begin
                        shreg  <= i_fifo_data;
                        state  <= START;
                        o_tx   <= 1'b0;
                        o_busy <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        timer <= '0;
                        idx   <= '0;
                        state <= DATA;
                        o_tx  <= shreg[0];
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (last_data) begin
                            idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            o_tx  <= (^shreg) ^ 1'(PARITY_ODD);
`else
                            state <= STOP;
                            o_tx  <= 1'b1;
`endif
                        end else begin
                            idx  <= idx + IW'(1);
                            o_tx <= shreg[idx + IW'(1)];
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        timer <= '0;
                        idx   <= '0;
                        state <= STOP;
                        o_tx  <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (last_stop) begin
                            idx <= '0;
                            if (o_fifo_rd_en) begin
                                // Next word is already popped: start bit follows with no gap.
                                shreg <= i_fifo_data;
                                state <= START;
                                o_tx  <= 1'b0;
                            end else begin
                                state  <= IDLE;
                                o_tx   <= 1'b1;
                                o_busy <= 1'b0;
                            end
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                default: begin
                    state  <= IDLE;
                    timer  <= '0;
                    idx    <= '0;
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with CLKS_PER_BIT=4, DATA_WIDTH=8.
// Three instances share one FIFO model; sel chooses which one is live.
//   inst 0: 1 stop bit, even parity   inst 1: 2 stop bits   inst 2: odd parity
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  int         sel;

  logic en0, en1, en2, emp0, emp1, emp2;
  logic rd0, rd1, rd2, tx0, tx1, tx2, busy0, busy1, busy2;
  logic rd_sel, tx_sel, busy_sel;

  assign en0  = (sel == 0) ? tx_en : 1'b0;
  assign en1  = (sel == 1) ? tx_en : 1'b0;
  assign en2  = (sel == 2) ? tx_en : 1'b0;
  assign emp0 = (sel == 0) ? fifo_empty : 1'b1;
  assign emp1 = (sel == 1) ? fifo_empty : 1'b1;
  assign emp2 = (sel == 2) ? fifo_empty : 1'b1;

  always_comb begin
    rd_sel = rd0; tx_sel = tx0; busy_sel = busy0;
    case (sel)
      1: begin rd_sel = rd1; tx_sel = tx1; busy_sel = busy1; end
      2: begin rd_sel = rd2; tx_sel = tx2; busy_sel = busy2; end
      default: ;
    endcase
  end

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .i_tx_en(en0), .i_fifo_empty(emp0), .i_fifo_data(fifo_data),
    .o_fifo_rd_en(rd0), .o_tx(tx0), .o_busy(busy0));
  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .i_tx_en(en1), .i_fifo_empty(emp1), .i_fifo_data(fifo_data),
    .o_fifo_rd_en(rd1), .o_tx(tx1), .o_busy(busy1));
  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst(rst), .i_tx_en(en2), .i_fifo_empty(emp2), .i_fifo_data(fifo_data),
    .o_fifo_rd_en(rd2), .o_tx(tx2), .o_busy(busy2));

  // ---------------- FIFO model ----------------
  logic [7:0] fq[$];
  logic       pend = 1'b0;
  int         pop_cnt = 0;

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    refresh();
  endtask

  always @(negedge clk) pend = rd_sel;

  always @(posedge clk) begin
    #1;
    if (pend && fq.size() != 0) begin
      void'(fq.pop_front());
      pop_cnt++;
    end
    pend = 1'b0;
    refresh();
  end

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Expected line level per cycle for one frame.
  function automatic void build(input logic [7:0] b, input int sb, input bit odd);
    for (int k = 0; k < CPB; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < CPB; k++) exp_q.push_back(b[i]);
    if (PAR_EN)
      for (int k = 0; k < CPB; k++) exp_q.push_back((^b) ^ odd);
    for (int k = 0; k < sb * CPB; k++) exp_q.push_back(1'b1);
  endfunction

  // A pop must never be requested while the FIFO reads empty.
  always @(negedge clk) begin
    total++;
    if (rd_sel === 1'b1 && fifo_empty === 1'b1) begin
      bad++;
      $display("FAIL rd_while_empty: rd_en=%b with empty=%b, required rd_en=0", rd_sel, fifo_empty);
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({tx0, tx1, tx2} !== 3'b111) begin
      bad++; $display("FAIL reset_tx: got %b required 111", {tx0, tx1, tx2});
    end
    total++;
    if ({busy0, busy1, busy2} !== 3'b000) begin
      bad++; $display("FAIL reset_busy: got %b required 000", {busy0, busy1, busy2});
    end
    total++;
    if ({rd0, rd1, rd2} !== 3'b000) begin
      bad++; $display("FAIL reset_rd_en: got %b required 000", {rd0, rd1, rd2});
    end
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    total++;
    if (tx_sel !== 1'b1 || busy_sel !== 1'b0) begin
      bad++; $display("FAIL reset_release: tx=%b busy=%b required tx=1 busy=0", tx_sel, busy_sel);
    end
  endtask

  task automatic test_single();
    bit got;
    int n, busy_n;
    logic e;
    sel = 0; exp_q.delete();
    build(8'h55, 1, 1'b0);
    n = exp_q.size();
    @(posedge clk); #2; tx_en = 1'b1; push(8'h55);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rd_sel === 1'b1) begin got = 1'b1; break; end
    end
    total++;
    if (!got) begin bad++; $display("FAIL single_pop: rd_en never rose, required one pulse"); end
    total++;
    if (tx_sel !== 1'b1 || busy_sel !== 1'b0) begin
      bad++; $display("FAIL single_pop_cycle: tx=%b busy=%b required tx=1 busy=0", tx_sel, busy_sel);
    end
    busy_n = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (tx_sel !== e || busy_sel !== 1'b1 || rd_sel !== 1'b0) begin
        bad++;
        $display("FAIL single_frame c=%0d: tx=%b busy=%b rd=%b required tx=%b busy=1 rd=0",
                 c, tx_sel, busy_sel, rd_sel, e);
      end
      if (busy_sel === 1'b1) busy_n++;
    end
    @(negedge clk);
    total++;
    if (tx_sel !== 1'b1 || busy_sel !== 1'b0) begin
      bad++; $display("FAIL single_idle: tx=%b busy=%b required tx=1 busy=0", tx_sel, busy_sel);
    end
    total++;
    if (busy_n != 40 + (PAR_EN ? 4 : 0)) begin
      bad++; $display("FAIL single_busy_len: got %0d required %0d", busy_n, 40 + (PAR_EN ? 4 : 0));
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    int n, busy_n, pops0;
    logic e;
    sel = 0; exp_q.delete();
    build(8'hA3, 1, 1'b0);
    build(8'h0F, 1, 1'b0);
    n = exp_q.size();
    @(posedge clk); #2; tx_en = 1'b1; push(8'hA3); push(8'h0F);
    pops0 = pop_cnt;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rd_sel === 1'b1) begin got = 1'b1; break; end
    end
    total++;
    if (!got) begin bad++; $display("FAIL b2b_pop1: rd_en never rose, required one pulse"); end
    busy_n = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (tx_sel !== e || busy_sel !== 1'b1 || rd_sel !== (c == n / 2)) begin
        bad++;
        $display("FAIL b2b_frame c=%0d: tx=%b busy=%b rd=%b required tx=%b busy=1 rd=%b",
                 c, tx_sel, busy_sel, rd_sel, e, (c == n / 2));
      end
      if (busy_sel === 1'b1) busy_n++;
    end
    @(negedge clk);
    total++;
    if (tx_sel !== 1'b1 || busy_sel !== 1'b0) begin
      bad++; $display("FAIL b2b_idle: tx=%b busy=%b required tx=1 busy=0", tx_sel, busy_sel);
    end
    total++;
    if (busy_n != 80 + (PAR_EN ? 8 : 0)) begin
      bad++; $display("FAIL b2b_busy_len: got %0d required %0d", busy_n, 80 + (PAR_EN ? 8 : 0));
    end
    total++;
    if (pop_cnt - pops0 != 2) begin
      bad++; $display("FAIL b2b_pop_count: got %0d required 2", pop_cnt - pops0);
    end
  endtask

  task automatic test_parity();
    bit got;
    int n, busy_n;
    logic e;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 0) ? 0 : 2;
      exp_q.delete();
      build(8'h07, 1, (s == 1));
      n = exp_q.size();
      @(posedge clk); #2; tx_en = 1'b1; push(8'h07);
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (rd_sel === 1'b1) begin got = 1'b1; break; end
      end
      total++;
      if (!got) begin bad++; $display("FAIL parity_pop sel=%0d: rd_en never rose", sel); end
      busy_n = 0;
      for (int c = 1; c <= n; c++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (tx_sel !== e || busy_sel !== 1'b1) begin
          bad++;
          $display("FAIL parity_frame sel=%0d c=%0d: tx=%b busy=%b required tx=%b busy=1",
                   sel, c, tx_sel, busy_sel, e);
        end
        if (busy_sel === 1'b1) busy_n++;
      end
      @(negedge clk);
      total++;
      if (busy_n != (PAR_EN ? 44 : 40) || busy_sel !== 1'b0) begin
        bad++;
        $display("FAIL parity_len sel=%0d: busy cycles %0d busy_now=%b required %0d and 0",
                 sel, busy_n, busy_sel, (PAR_EN ? 44 : 40));
      end
    end
  endtask

  task automatic test_two_stop();
    bit got;
    int n, busy_n;
    logic e;
    sel = 1; exp_q.delete();
    build(8'h00, 2, 1'b0);
    n = exp_q.size();
    @(posedge clk); #2; tx_en = 1'b1; push(8'h00);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rd_sel === 1'b1) begin got = 1'b1; break; end
    end
    total++;
    if (!got) begin bad++; $display("FAIL two_stop_pop: rd_en never rose"); end
    busy_n = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (tx_sel !== e || busy_sel !== 1'b1) begin
        bad++;
        $display("FAIL two_stop_frame c=%0d: tx=%b busy=%b required tx=%b busy=1",
                 c, tx_sel, busy_sel, e);
      end
      if (busy_sel === 1'b1) busy_n++;
    end
    @(negedge clk);
    total++;
    if (busy_n != 44 + (PAR_EN ? 4 : 0) || busy_sel !== 1'b0) begin
      bad++;
      $display("FAIL two_stop_len: busy cycles %0d busy_now=%b required %0d and 0",
               busy_n, busy_sel, 44 + (PAR_EN ? 4 : 0));
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    int pops0, odd_cyc;
    sel = 0;
    @(posedge clk); #2; tx_en = 1'b1; push(8'hFF);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rd_sel === 1'b1) begin got = 1'b1; break; end
    end
    total++;
    if (!got) begin bad++; $display("FAIL rmid_pop: rd_en never rose"); end
    // cycles 1..4 start, 5..8 bit0, 9..12 bit1, 13..16 bit2
    repeat (13) @(negedge clk);
    @(posedge clk); #2; rst = 1'b1;
    @(negedge clk);
    total++;
    if (tx_sel !== 1'b1 || busy_sel !== 1'b1) begin
      bad++; $display("FAIL rmid_bit2: tx=%b busy=%b required tx=1 busy=1", tx_sel, busy_sel);
    end
    @(negedge clk);
    total++;
    if (tx_sel !== 1'b1 || busy_sel !== 1'b0) begin
      bad++; $display("FAIL rmid_abort: tx=%b busy=%b required tx=1 busy=0", tx_sel, busy_sel);
    end
    @(posedge clk); #2; rst = 1'b0;
    pops0 = pop_cnt;
    odd_cyc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (tx_sel !== 1'b1 || busy_sel !== 1'b0 || rd_sel !== 1'b0) odd_cyc++;
    end
    total++;
    if (odd_cyc != 0 || pop_cnt != pops0) begin
      bad++;
      $display("FAIL rmid_quiet: active cycles %0d pops %0d required 0 and 0",
               odd_cyc, pop_cnt - pops0);
    end
    @(posedge clk); #2; push(8'h12);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rd_sel === 1'b1) begin got = 1'b1; break; end
    end
    total++;
    if (!got) begin bad++; $display("FAIL rmid_repop: rd_en=0 after refill, required 1"); end
    repeat (50) @(negedge clk);
  endtask

  task automatic test_tx_en();
    bit got;
    int n, pops0, odd_cyc;
    logic e;
    sel = 0; exp_q.delete();
    @(posedge clk); #2; tx_en = 1'b0; push(8'h3C);
    pops0 = pop_cnt;
    odd_cyc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rd_sel !== 1'b0 || tx_sel !== 1'b1) odd_cyc++;
    end
    total++;
    if (odd_cyc != 0 || pop_cnt != pops0) begin
      bad++;
      $display("FAIL txen_hold: active cycles %0d pops %0d required 0 and 0",
               odd_cyc, pop_cnt - pops0);
    end
    build(8'h3C, 1, 1'b0);
    n = exp_q.size();
    @(posedge clk); #2; tx_en = 1'b1; push(8'h81);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rd_sel === 1'b1) begin got = 1'b1; break; end
    end
    total++;
    if (!got) begin bad++; $display("FAIL txen_pop: rd_en never rose"); end
    for (int c = 1; c <= n + 20; c++) begin
      @(negedge clk);
      e = (c <= n) ? exp_q.pop_front() : 1'b1;
      total++;
      if (tx_sel !== e || busy_sel !== (c <= n) || rd_sel !== 1'b0) begin
        bad++;
        $display("FAIL txen_drop c=%0d: tx=%b busy=%b rd=%b required tx=%b busy=%b rd=0",
                 c, tx_sel, busy_sel, rd_sel, e, (c <= n));
      end
      if (c == 10) begin @(posedge clk); #2; tx_en = 1'b0; end
    end
    total++;
    if (pop_cnt - pops0 != 1) begin
      bad++; $display("FAIL txen_pop_count: got %0d required 1", pop_cnt - pops0);
    end
    @(posedge clk); #2; tx_en = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rd_sel === 1'b1) begin got = 1'b1; break; end
    end
    total++;
    if (!got || fifo_data !== 8'h81) begin
      bad++; $display("FAIL txen_resume: rd=%b head=%h required rd=1 head=81", got, fifo_data);
    end
    repeat (50) @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; tx_en = 1'b0; sel = 0;
    refresh();
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_two_stop();
    test_reset_mid();
    test_tx_en();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
